// File: rtl/execute_pipe.sv
// Y86 execute stage: ALU, condition evaluation and condition-code register behind
// a single-entry valid/ready output register.
module execute_pipe #(
  parameter int W    = 64,
  parameter int STEP = W / 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic         cc_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic         out_cnd,
  output logic [2:0]   cc
);

  logic         r_out_valid;
  logic [3:0]   r_out_icode;
  logic [W-1:0] r_out_valE;
  logic [W-1:0] r_out_valA;
  logic         r_out_cnd;
  logic [2:0]   r_cc;            // {OF, ZF, SF}

  logic         w_accept;
  logic [W-1:0] w_alu;
  logic [W-1:0] w_valE;
  logic         w_is_op;
  logic         w_of;
  logic [2:0]   w_cc_new;
  logic         w_cc_we;
  logic         w_cond;
  logic         w_cnd;
  logic         w_sf;
  logic         w_zf;
  logic         w_ofc;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_alu   = '0;
    w_of    = 1'b0;
    w_is_op = (icode == 4'h6) && (ifun <= 4'h3);
    case (ifun)
      4'h0: begin
        w_alu = valB + valA;
        w_of  = (valA[W-1] == valB[W-1]) && (w_alu[W-1] != valB[W-1]);
      end
      4'h1: begin
        w_alu = valB - valA;
        w_of  = (valA[W-1] != valB[W-1]) && (w_alu[W-1] != valB[W-1]);
      end
      4'h2:    w_alu = valB & valA;
      4'h3:    w_alu = valB ^ valA;
      default: w_alu = '0;
    endcase
    w_cc_new = {w_of, (w_alu == '0), w_alu[W-1]};
    w_cc_we  = w_accept && w_is_op && !cc_block;
  end

  always_comb begin
    w_valE = '0;
    case (icode)
      4'h2:        w_valE = valA;
      4'h3:        w_valE = valC;
      4'h4, 4'h5:  w_valE = valB + valC;
      4'h6:        w_valE = w_alu;
      4'h8, 4'hA:  w_valE = valB - W'(STEP);
      4'h9, 4'hB:  w_valE = valB + W'(STEP);
      default:     w_valE = '0;
    endcase
  end

  // Condition uses the flags held before this instruction's own CC update.
  always_comb begin
    w_ofc  = r_cc[2];
    w_zf   = r_cc[1];
    w_sf   = r_cc[0];
    w_cond = 1'b0;
    case (ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = (w_sf ^ w_ofc) | w_zf;
      4'h2:    w_cond = w_sf ^ w_ofc;
      4'h3:    w_cond = w_zf;
      4'h4:    w_cond = !w_zf;
      4'h5:    w_cond = !(w_sf ^ w_ofc);
      4'h6:    w_cond = !(w_sf ^ w_ofc) && !w_zf;
      default: w_cond = 1'b0;
    endcase
    w_cnd = ((icode == 4'h2) || (icode == 4'h7)) ? w_cond : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_icode <= '0;
      r_out_valE  <= '0;
      r_out_valA  <= '0;
      r_out_cnd   <= 1'b0;
      r_cc        <= 3'b010;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_icode <= icode;
        r_out_valE  <= w_valE;
        r_out_valA  <= valA;
        r_out_cnd   <= w_cnd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_cc_we) begin
        r_cc <= w_cc_new;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign out_valE  = r_out_valE;
  assign out_valA  = r_out_valA;
  assign out_cnd   = r_out_cnd;
  assign cc        = r_cc;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: directed vectors push expectations, a monitor
// pops and compares on every output handshake.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        cc_block;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic        out_cnd;
  logic [2:0]  cc;

  logic        in_valid32;
  logic        in_ready32;
  logic [3:0]  icode32;
  logic [31:0] valB32;
  logic        out_valid32;
  logic [3:0]  out_icode32;
  logic [31:0] out_valE32;
  logic [31:0] out_valA32;
  logic        out_cnd32;
  logic [2:0]  cc32;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  execute_pipe #(.W(64), .STEP(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .cc_block(cc_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
    .out_cnd(out_cnd), .cc(cc)
  );

  execute_pipe #(.W(32), .STEP(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .icode(icode32), .ifun(4'h0), .valA(32'h0), .valB(valB32), .valC(32'h0),
    .cc_block(1'b0), .out_valid(out_valid32), .out_ready(1'b1),
    .out_icode(out_icode32), .out_valE(out_valE32), .out_valA(out_valA32),
    .out_cnd(out_cnd32), .cc(cc32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake consumes exactly one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got icode 0x%0h valE 0x%0h expected no output",
                 out_icode, out_valE);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_icode", 64'(out_icode), 64'(e.icode));
        check("out_valE", out_valE, e.valE);
        check("out_valA", out_valA, e.valA);
        check("out_cnd", 64'(out_cnd), 64'(e.cnd));
        check("cc", 64'(cc), 64'(e.cc));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted it.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic blk, input logic [63:0] ev, input logic ec,
                      input logic [2:0] ecc);
    bit acc = 0;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; cc_block = blk;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        q.push_back('{icode: ic, valE: ev, valA: a, cnd: ec, cc: ecc});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FE   = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0;
    valC = '0; cc_block = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; icode32 = '0; valB32 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_icode", 64'(out_icode), 64'd0);
    check("rst_out_valE", out_valE, 64'd0);
    check("rst_out_valA", out_valA, 64'd0);
    check("rst_out_cnd", 64'(out_cnd), 64'd0);
    check("rst_cc", 64'(cc), 64'b010);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // icode, ifun, valA, valB, valC, cc_block, valE, cnd, cc after
    send(4'h6, 4'h0, 64'd5, 64'd3, 0, 0, 64'd8, 0, 3'b000);
    send(4'h6, 4'h1, 64'd5, 64'd3, 0, 0, FE, 0, 3'b001);
    send(4'h7, 4'h2, 0, 0, 0, 0, 0, 1, 3'b001);
    send(4'h6, 4'h0, MAXP, MAXP, 0, 0, FE, 0, 3'b101);
    send(4'h6, 4'h0, 64'd1, 64'd1, 0, 0, 64'd2, 0, 3'b000);
    send(4'h6, 4'h0, MAXP, MAXP, 0, 1, FE, 0, 3'b000);
    send(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 0, 0, 64'hF000, 0, 3'b000);
    send(4'h6, 4'h3, 64'h1234, 64'h1234, 0, 0, 64'd0, 0, 3'b010);
    send(4'h7, 4'h3, 0, 0, 0, 0, 0, 1, 3'b010);
    send(4'h7, 4'h4, 0, 0, 0, 0, 0, 0, 3'b010);
    send(4'h2, 4'h1, 64'hAB, 0, 0, 0, 64'hAB, 1, 3'b010);
    send(4'h6, 4'h4, 64'd1, 64'd1, 0, 0, 64'd0, 0, 3'b010);
    send(4'h4, 4'h0, 0, 64'h10, 64'h20, 0, 64'h30, 0, 3'b010);
    send(4'h5, 4'h0, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'hFF0, 0, 3'b010);
    send(4'h3, 4'h0, 64'h77, 0, 64'hDEAD, 0, 64'hDEAD, 0, 3'b010);
    send(4'h8, 4'h0, 0, 64'h100, 0, 0, 64'hF8, 0, 3'b010);
    send(4'hB, 4'h0, 0, 64'h100, 0, 0, 64'h108, 0, 3'b010);
    send(4'hA, 4'h0, 0, 64'h10, 0, 0, 64'h8, 0, 3'b010);
    send(4'h9, 4'h0, 0, 64'h0, 0, 0, 64'h8, 0, 3'b010);
    send(4'h1, 4'h0, 64'h5, 64'h5, 64'h5, 0, 64'd0, 0, 3'b010);
    send(4'hF, 4'h0, 64'h5, 64'h5, 64'h5, 0, 64'd0, 0, 3'b010);
    send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 0, MAXP, 0, 3'b100);
    send(4'h7, 4'h2, 0, 0, 0, 0, 0, 1, 3'b100);
    send(4'h7, 4'h5, 0, 0, 0, 0, 0, 0, 3'b100);
    send(4'h7, 4'h6, 0, 0, 0, 0, 0, 0, 3'b100);
    send(4'h7, 4'h1, 0, 0, 0, 0, 0, 1, 3'b100);
    send(4'h7, 4'h0, 0, 0, 0, 0, 0, 1, 3'b100);
    send(4'h7, 4'h7, 0, 0, 0, 0, 0, 0, 3'b100);
    send(4'h6, 4'h1, 64'd5, 64'd5, 0, 0, 64'd0, 0, 3'b010);
    send(4'h7, 4'h6, 0, 0, 0, 0, 0, 0, 3'b010);
    send(4'h7, 4'h5, 0, 0, 0, 0, 0, 1, 3'b010);
    drain();

    // Backpressure: hold A in the output register while B waits on the input.
    out_ready = 1'b0;
    send(4'h3, 4'h0, 64'h9, 0, 64'h1111, 0, 64'h1111, 0, 3'b010);
    icode = 4'h6; ifun = 4'h0; valA = 64'd2; valB = 64'd3; valC = '0; cc_block = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_valE", out_valE, 64'h1111);
      check("stall_out_icode", 64'(out_icode), 64'h3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    q.push_back('{icode: 4'h6, valE: 64'd5, valA: 64'd2, cnd: 1'b0, cc: 3'b000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Reset while a result is held: output and pending expectation are discarded.
    out_ready = 1'b0;
    send(4'h6, 4'h0, MAXP, MAXP, 0, 0, FE, 0, 3'b101);
    @(negedge clk);
    check("pre_rst_cc", 64'(cc), 64'b101);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    icode = 4'h6; ifun = 4'h1; valA = 64'd5; valB = 64'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_cc", 64'(cc), 64'b010);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(4'h2, 4'h3, 64'h55, 64'h1, 0, 0, 64'h55, 1, 3'b010);
    drain();

    // Narrow instance: stack pointer step of 4.
    in_valid32 = 1'b1; icode32 = 4'h8; valB32 = 32'h100;
    @(posedge clk); #1;
    check("w32_push_valid", 64'(out_valid32), 64'd1);
    check("w32_push_valE", 64'(out_valE32), 64'hFC);
    icode32 = 4'hB;
    @(posedge clk); #1;
    check("w32_ret_valE", 64'(out_valE32), 64'h104);
    in_valid32 = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
